// File: rtl/triangle_pkg.sv
// Shared types and helpers for the triangle side-check scanner.
package triangle_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Precondition: a <= b <= c, so a single strict sum test decides it.
   function automatic logic is_triangle(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum > {1'b0, c};
   endfunction

endpackage

// File: rtl/triangle_check.sv
// Combinational strict triangle test on three sides in any order.
module triangle_check
   import triangle_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             is_tri
);

   // Checking every side against the other two removes the sorted-input precondition.
   always_comb begin
      is_tri = is_triangle(32'(a), 32'(b), 32'(c)) &&
               is_triangle(32'(a), 32'(c), 32'(b)) &&
               is_triangle(32'(b), 32'(c), 32'(a));
   end

endmodule

// File: rtl/triangle_scan.sv
// Enumerates sorted side triples 1..LIMIT, classifies them and streams them out.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for START; outputs hold last scan result
//   ST_RUN  | VALID=1, presenting a triple until accepted
//   ST_FIN  | DONE pulse for one cycle, then back to ST_IDLE
module triangle_scan
   import triangle_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             READY,
   output logic             VALID,
   output logic [WIDTH-1:0] A_OUT,
   output logic [WIDTH-1:0] B_OUT,
   output logic [WIDTH-1:0] C_OUT,
   output logic             IS_TRI,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] COUNT
);

   localparam logic [WIDTH-1:0] SIDE_ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_tri;
   logic             accept;

   triangle_check #(.WIDTH(WIDTH)) u_check (
      .a      (a_q),
      .b      (b_q),
      .c      (c_q),
      .is_tri (is_tri)
   );

   assign accept = (state_q == ST_RUN) && READY;

   always_comb begin
      state_d = state_q;
      lim_d   = lim_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               cnt_d = '0;
               lim_d = LIMIT;
               if (LIMIT != '0) begin
                  state_d = ST_RUN;
                  a_d     = SIDE_ONE;
                  b_d     = SIDE_ONE;
                  c_d     = SIDE_ONE;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (is_tri) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // Compare before incrementing so LIMIT = max never wraps a side.
               if (c_q < lim_q) begin
                  c_d = c_q + SIDE_ONE;
               end else if (b_q < lim_q) begin
                  b_d = b_q + SIDE_ONE;
                  c_d = b_q + SIDE_ONE;
               end else if (a_q < lim_q) begin
                  a_d = a_q + SIDE_ONE;
                  b_d = a_q + SIDE_ONE;
                  c_d = a_q + SIDE_ONE;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         lim_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lim_q   <= lim_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   assign VALID  = (state_q == ST_RUN);
   assign BUSY   = (state_q == ST_RUN);
   assign DONE   = (state_q == ST_FIN);
   assign A_OUT  = a_q;
   assign B_OUT  = b_q;
   assign C_OUT  = c_q;
   assign IS_TRI = is_tri;
   assign COUNT  = cnt_q;

endmodule
